// File: rtl/btb_branch_predictor_pkg.sv
// Shared constants and slice helpers for the branch target buffer.
// Index/tag positions are derived from ENTRIES/TAG_BITS via constant functions.
package btb_branch_predictor_pkg;

  localparam int DEF_ENTRIES  = 64;
  localparam int DEF_TAG_BITS = 12;
  localparam int DEF_CNT_BITS = 2;
  localparam int DEF_CNT_INIT = 2;

  // Index occupies pc[TAG_LO-1:2]; tag sits directly above it.
  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_lo(input int entries);
    return $clog2(entries) + 2;
  endfunction

  function automatic int tag_hi(input int entries, input int tag_bits);
    return $clog2(entries) + 1 + tag_bits;
  endfunction

  function automatic int cnt_max(input int cnt_bits);
    return (1 << cnt_bits) - 1;
  endfunction

  function automatic int cnt_taken_bit(input int cnt_bits);
    return cnt_bits - 1;
  endfunction

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } btb_upd_t;

endpackage

// File: rtl/btb_branch_predictor_sat_counter.sv
// Saturating up/down direction counter step (pure combinational).
module sat_counter_update
  import btb_branch_predictor_pkg::*;
#(
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic [CNT_BITS-1:0] cnt_i,
  input  logic                inc_i,
  output logic [CNT_BITS-1:0] cnt_o
);

  localparam logic [CNT_BITS-1:0] MAX = CNT_BITS'(cnt_max(CNT_BITS));

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != MAX) cnt_o = cnt_i + CNT_BITS'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: zero-latency lookup at IF,
// training from EX, plus lookup/mispredict statistics.
module btb_branch_predictor
  import btb_branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = DEF_ENTRIES,
  parameter int TAG_BITS = DEF_TAG_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS,
  parameter int CNT_INIT = DEF_CNT_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  input  logic        lookup_en,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispreds
);

  localparam int IDX    = idx_bits(ENTRIES);
  localparam int TAG_LO = tag_lo(ENTRIES);
  localparam int TAG_HI = tag_hi(ENTRIES, TAG_BITS);
  localparam int TKN    = cnt_taken_bit(CNT_BITS);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q [ENTRIES];

  logic [31:0] lookups_q, lookups_d;
  logic [31:0] mispreds_q, mispreds_d;

  // Lookup path
  logic [IDX-1:0]      lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_idx = pc_if[TAG_LO-1:2];
  assign lk_tag = pc_if[TAG_HI:TAG_LO];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // Reset gating keeps IF on the fall-through path while the table is being cleared.
  assign pred_taken  = !rst && lk_hit && cnt_q[lk_idx][TKN];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : pc_if + 32'd4;

  // Update path
  btb_upd_t            upd;
  logic [IDX-1:0]      upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                upd_wr;
  logic [CNT_BITS-1:0] cnt_step;
  logic [CNT_BITS-1:0] cnt_d;

  assign upd     = '{en: upd_en, pc: upd_pc, taken: upd_taken, target: upd_target};
  assign upd_idx = upd.pc[TAG_LO-1:2];
  assign upd_tag = upd.pc[TAG_HI:TAG_LO];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter_update #(.CNT_BITS(CNT_BITS)) u_cnt (
    .cnt_i (cnt_q[upd_idx]),
    .inc_i (upd.taken),
    .cnt_o (cnt_step)
  );

  always_comb begin
    upd_wr = upd.en && (upd_hit || upd.taken);
    cnt_d  = upd_hit ? cnt_step : CNT_BITS'(CNT_INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_wr) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && upd_wr) begin
      tag_q[upd_idx] <= upd_tag;
      cnt_q[upd_idx] <= cnt_d;
      if (upd.taken) tgt_q[upd_idx] <= upd.target;
    end
  end

  // Statistics
  always_comb begin
    lookups_d  = lookups_q + {31'd0, lookup_en};
    mispreds_d = mispreds_q + {31'd0, upd_en & upd_mispred};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q  <= '0;
      mispreds_q <= '0;
    end else begin
      lookups_q  <= lookups_d;
      mispreds_q <= mispreds_d;
    end
  end

  assign stat_lookups  = lookups_q;
  assign stat_mispreds = mispreds_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if, upd_pc};

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Randomised scoreboard bench for btb_branch_predictor against an abstract table model.
module tb_btb_branch_predictor;

  localparam int ENTRIES  = 64;
  localparam int TAG_BITS = 12;
  localparam int CNT_BITS = 2;
  localparam int CNT_INIT = 2;
  localparam int IDXB     = $clog2(ENTRIES);
  localparam int CMAX     = (1 << CNT_BITS) - 1;
  localparam int CTAKEN   = 1 << (CNT_BITS - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_if = 32'h100;
  logic        lookup_en = 1'b0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;
  logic [31:0] stat_lookups, stat_mispreds;

  btb_branch_predictor #(
    .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS), .CNT_INIT(CNT_INIT)
  ) dut (
    .clk(clk), .rst(rst), .pc_if(pc_if), .lookup_en(lookup_en),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .stat_lookups(stat_lookups), .stat_mispreds(stat_mispreds)
  );

  always #5 clk = ~clk;

  // Reference model: a plain table indexed arithmetically from the PC.
  bit          m_v   [ENTRIES];
  int unsigned m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];
  logic [31:0] m_lk = '0, m_mp = '0;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [31:0] lk;
    logic [31:0] mp;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0, n_total = 0;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc >> (IDXB + 2)) % (1 << TAG_BITS);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[m_index(pc)] && m_tag[m_index(pc)] == m_tagof(pc);
  endfunction

  task automatic m_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    int i = m_index(pc);
    if (m_hit(pc)) begin
      if (taken) begin
        m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        m_tgt[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (taken) begin
      m_v[i] = 1; m_tag[i] = m_tagof(pc); m_tgt[i] = tgt; m_cnt[i] = CNT_INIT;
    end
  endtask

  // Drive one cycle: commit the previous cycle's effect into the model, then
  // present new inputs and queue the response the DUT must show this cycle.
  task automatic cyc(input logic r, input logic lk, input logic [31:0] pc,
                     input logic ue, input logic [31:0] upc, input logic ut,
                     input logic [31:0] utg, input logic um);
    exp_t e;
    @(posedge clk);
    if (rst) begin
      foreach (m_v[i]) m_v[i] = 0;
      m_lk = '0; m_mp = '0;
    end else begin
      if (lookup_en) m_lk = m_lk + 32'd1;
      if (upd_en && upd_mispred) m_mp = m_mp + 32'd1;
      if (upd_en) m_update(upd_pc, upd_taken, upd_target);
    end
    #1;
    rst = r; lookup_en = lk; pc_if = pc; upd_en = ue; upd_pc = upc;
    upd_taken = ut; upd_target = utg; upd_mispred = um;
    e.pc     = pc;
    e.taken  = !r && m_hit(pc) && m_cnt[m_index(pc)] >= CTAKEN;
    e.target = e.taken ? m_tgt[m_index(pc)] : pc + 32'd4;
    e.lk     = m_lk;
    e.mp     = m_mp;
    exp_q.push_back(e);
  endtask

  task automatic lk_only(input logic [31:0] pc);
    cyc(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    cyc(1'b0, 1'b1, pc, 1'b1, pc, t, tgt, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] pc, input logic [31:0] act,
                     input logic [31:0] expv);
    n_total++;
    if (act !== expv)
      $display("FAIL %s pc=%08h got=%08h exp=%08h at %0t", nm, pc, act, expv, $time);
    else
      n_pass++;
  endtask

  // Monitor: the DUT presents a prediction every cycle; check mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pred_taken",    e.pc, {31'd0, pred_taken}, {31'd0, e.taken});
        chk("pred_target",   e.pc, pred_target,   e.target);
        chk("stat_lookups",  e.pc, stat_lookups,  e.lk);
        chk("stat_mispreds", e.pc, stat_mispreds, e.mp);
      end
    end
  end

  logic [31:0] pool [8];

  initial begin
    logic [31:0] p, u;
    pool = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h1100, 32'h140, 32'h204, 32'h400};

    cyc(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
    lk_only(32'h100);
    train(32'h100, 1'b1, 32'h40);
    lk_only(32'h100);
    repeat (3) train(32'h100, 1'b1, 32'h40);
    repeat (2) train(32'h100, 1'b0, 32'h0);
    lk_only(32'h100);
    repeat (2) train(32'h100, 1'b0, 32'h0);
    lk_only(32'h100);

    // Aliasing on index 0
    cyc(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    train(32'h100, 1'b1, 32'h40);
    train(32'h200, 1'b1, 32'h80);
    lk_only(32'h100);
    lk_only(32'h200);

    // Same-cycle lookup/update hazard
    train(32'h100, 1'b1, 32'h40);
    train(32'h100, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44, 1'b1);
    lk_only(32'h100);

    // Statistics run: 5 lookups, 2 mispredicts
    cyc(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 32'h300, i < 2, 32'h140, 1'b0, 32'h0, i < 2);
    cyc(1'b0, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Randomised phase, including occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(7)];
      u = pool[$urandom_range(7)];
      cyc($urandom_range(60) == 0, 1'($urandom_range(1)), p, 1'($urandom_range(1)), u,
          1'($urandom_range(1)), $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(1)));
    end

    // Reset mid-run, then every pooled PC must miss
    cyc(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 8; i++) lk_only(pool[i]);

    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btb_branch_predictor.md
Name: btb_branch_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the IF stage of the RV32I pipeline.
- Predicts taken/target for the fetch PC in the same cycle, so taken branches and jal no longer need a redirect from EX.
- Trained from the EX stage once branch/jal/jalr resolution is known.
- Keeps lookup and mispredict statistics for the debug/perf path.

Parameters:
- ENTRIES, 64, number of direct-mapped entries; power of two, 4..1024.
- TAG_BITS, 12, stored tag width; constraint log2(ENTRIES)+TAG_BITS+2 <= 32.
- CNT_BITS, 2, direction counter width, 1..4.
- CNT_INIT, 2, counter value written on allocation; weakly-taken for CNT_BITS=2; must be < 2^CNT_BITS.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_if  in  32  current fetch PC; word-aligned.
- lookup_en  in  1  fetch is advancing (not bubbleF); gates the statistics only.
- pred_taken  out  1  predict redirect, combinational from pc_if and table state.
- pred_target  out  32  predicted NPC when pred_taken=1, else pc_if+4.
- upd_en  in  1  EX holds a resolved control-transfer instruction (branch/jal/jalr) this cycle.
- upd_pc  in  32  PC of the resolving instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_mispred  in  1  EX flagged a misprediction (direction or target); used only for statistics.
- stat_lookups  out  32  count of cycles with lookup_en=1.
- stat_mispreds  out  32  count of cycles with upd_en&upd_mispred.

Behaviour:
- IDX = log2(ENTRIES). Index = pc[IDX+1:2]. Tag = pc[IDX+1+TAG_BITS:IDX+2].
- Entry state: valid, tag, target[31:0], cnt[CNT_BITS-1:0].
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - pred_taken = hit & cnt MSB set.
  - pred_target = pred_taken ? target : pc_if+4.
- Update, on clock edge when upd_en=1; idx/tag are taken from upd_pc.
  - Hit and upd_taken: cnt saturating increment (stays at max); target overwritten with upd_target.
  - Hit and !upd_taken: cnt saturating decrement (stays at 0); target unchanged.
  - Miss and upd_taken: allocate. valid=1, tag written, target=upd_target, cnt=CNT_INIT. Any prior occupant is replaced (direct-mapped).
  - Miss and !upd_taken: no table change.
- Simultaneous lookup and update to the same index: lookup returns pre-update state. No write-to-read bypass.
- upd_en=0: table unchanged; upd_* inputs are ignored.
- Statistics counters:
  - Each increments by 1 per qualifying cycle.
  - Wrap modulo 2^32.
  - Both may increment in the same cycle.
- Reset (rst=1 at an edge):
  - All valid bits cleared and both stat counters set to 0 in that cycle.
  - Tag, target and cnt are don't-care.
  - Any update presented in the reset cycle is discarded.
- While rst is held: pred_taken=0 and pred_target=pc_if+4.
- First cycle after reset deassertion: every lookup misses.
- Predictor state does not affect architectural correctness. EX still compares upd_target/upd_taken against the prediction carried down the pipe and flushes on mismatch.

Decomposition:
- Shared package holds:
  - the index/tag slice helper constants (IDX, TAG_LO, TAG_HI);
  - the counter saturate limits CNT_MAX and CNT_TAKEN_BIT.
- One natural sub-module: sat_counter_update. Combinational inc/dec with saturation, parametrised by CNT_BITS.
- The table itself stays inline in btb_branch_predictor as flop arrays, so reset can clear valid in one cycle.

Test Plan:
- Reset then lookup pc_if=0x0000_0100 -> pred_taken=0, pred_target=0x0000_0104, stat counters=0.
- Train: upd_en=1, upd_pc=0x100, upd_taken=1, upd_target=0x0000_0040; next cycle pc_if=0x100 -> pred_taken=1, pred_target=0x40 (cnt=2).
- Saturation (CNT_BITS=2):
  - Three more taken updates of 0x100 -> cnt=3 (held).
  - Then two not-taken -> cnt=1, pred_taken=0.
  - Then two more not-taken -> cnt stays 0.
- Alias: ENTRIES=64, allocate 0x100, then taken update of 0x200 (same index, different tag, target 0x80) -> lookup 0x100 misses (pred_target=0x104), lookup 0x200 hits with target 0x80.
- Same-cycle hazard: with 0x100 weakly not-taken (cnt=1), present lookup 0x100 and taken update 0x100 together -> that cycle pred_taken=0, next cycle pred_taken=1.
- Statistics:
  - 5 cycles lookup_en=1 with 2 of them upd_en&upd_mispred -> stat_lookups=5, stat_mispreds=2.
  - Preload stat_lookups to 0xFFFF_FFFF via a run, one more lookup -> 0.
  - rst mid-run -> both 0 and all entries miss.
